// File: rtl/segdisp_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: register offsets,
// CTRL bit positions and the hex glyph table (active-high, bits 6:0 = g..a).
package segdisp_scan_pkg;

  // Offsets of DP mask and CTRL, counted from the first address after the data bytes
  localparam int unsigned DP_OFS   = 0;
  localparam int unsigned CTRL_OFS = 1;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_LZS_BIT = 1;

  typedef struct packed {
    logic lzs;
    logic en;
  } ctrl_t;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [7:0] ctrl_pack(input ctrl_t c);
    logic [7:0] r;
    r               = '0;
    r[CTRL_EN_BIT]  = c.en;
    r[CTRL_LZS_BIT] = c.lzs;
    return r;
  endfunction

endpackage

// File: rtl/segdisp_scan_if.sv
// Register bus of the display scanner: chip select, write strobe, address,
// write data and combinational read data.
interface segdisp_scan_if;
  logic       cs;
  logic       we;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output cs, we, addr, wdata, input rdata);
  modport slave  (input cs, we, addr, wdata, output rdata);
endinterface

// File: rtl/segdisp_scan_seg7_hexdec.sv
// Hex nibble to active-high 7-segment pattern (bits 6:0 = g..a).
module seg7_hexdec
  import segdisp_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_GLYPH[hex];
  end

endmodule

// File: rtl/segdisp_scan.sv
// Multiplexed 7-segment display scanner with register bank, blanking gap,
// leading-zero suppression and configurable output polarities.
module segdisp_scan
  import segdisp_scan_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DIV         = 2048,
  parameter int BLANK       = 2,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  segdisp_scan_if.slave      bus,
  output logic [7:0]         seg,
  output logic [DIGITS-1:0]  dig,
  output logic               frame
);

  localparam int NBYTES = DIGITS / 2;
  localparam int SLOT_W = $clog2(DIGITS);
  localparam int CNT_W  = $clog2(DIV);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_C   = CNT_W'(BLANK);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);
  localparam logic [3:0]        ADDR_DP   = 4'(NBYTES + DP_OFS);
  localparam logic [3:0]        ADDR_CTRL = 4'(NBYTES + CTRL_OFS);
  localparam logic [7:0]        SEG_DARK  = {8{SEG_ACT_LOW}};
  localparam logic [DIGITS-1:0] DIG_IDLE  = {DIGITS{DIG_ACT_LOW}};

  logic [4*DIGITS-1:0] nib_q;
  logic [DIGITS-1:0]   dp_q;
  ctrl_t               ctrl_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [SLOT_W-1:0]   slot_q;
  logic                frame_q;
  logic [7:0]          seg_q;
  logic [DIGITS-1:0]   dig_q;

  logic                wr_en;
  logic [3:0]          sel_nib;
  logic                sel_dp;
  logic                suppress;
  logic [6:0]          glyph;
  logic [7:0]          seg_lit;
  logic [DIGITS-1:0]   dig_lit;
  logic [7:0]          rd;

  assign wr_en = bus.cs & bus.we;

  // Register bank
  always_ff @(posedge clk) begin
    if (!rst) begin
      nib_q  <= '0;
      dp_q   <= '0;
      ctrl_q <= '{lzs: 1'b0, en: 1'b1};
    end else if (wr_en) begin
      for (int unsigned k = 0; k < NBYTES; k++) begin
        if (bus.addr == 4'(k)) nib_q[8*k +: 8] <= bus.wdata;
      end
      if (bus.addr == ADDR_DP) dp_q <= bus.wdata[DIGITS-1:0];
      if (bus.addr == ADDR_CTRL) begin
        ctrl_q.en  <= bus.wdata[CTRL_EN_BIT];
        ctrl_q.lzs <= bus.wdata[CTRL_LZS_BIT];
      end
    end
  end

  // Prescaler and slot index; frame marks the first clk of slot 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      slot_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        if (slot_q == SLOT_LAST) begin
          slot_q  <= '0;
          frame_q <= 1'b1;
        end else begin
          slot_q <= slot_q + 1'b1;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Current slot's nibble, DP bit and leading-zero status
  always_comb begin
    sel_nib  = '0;
    sel_dp   = 1'b0;
    suppress = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        sel_nib = nib_q[4*i +: 4];
        sel_dp  = dp_q[i];
      end
    end
    if (ctrl_q.lzs && slot_q != '0) begin
      suppress = 1'b1;
      for (int unsigned j = 0; j < DIGITS; j++) begin
        if (j >= 32'(slot_q) && nib_q[4*j +: 4] != 4'h0) suppress = 1'b0;
      end
    end
  end

  seg7_hexdec u_hexdec (
    .hex (sel_nib),
    .seg (glyph)
  );

  always_comb begin
    seg_lit = '0;
    dig_lit = '0;
    if (ctrl_q.en) begin
      seg_lit = {sel_dp, suppress ? 7'h00 : glyph};
      for (int unsigned i = 0; i < DIGITS; i++) begin
        dig_lit[i] = (cnt_q >= BLANK_C) && (slot_q == SLOT_W'(i));
      end
    end
  end

  // Polarity is applied by XOR with the idle pattern, so reset drives idle directly
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_q <= SEG_DARK;
      dig_q <= DIG_IDLE;
    end else begin
      seg_q <= seg_lit ^ SEG_DARK;
      dig_q <= dig_lit ^ DIG_IDLE;
    end
  end

  always_comb begin
    rd = '0;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (bus.addr == 4'(k)) rd = nib_q[8*k +: 8];
    end
    if (bus.addr == ADDR_DP)   rd = 8'(dp_q);
    if (bus.addr == ADDR_CTRL) rd = ctrl_pack(ctrl_q);
  end

  assign bus.rdata = rd;
  assign seg       = seg_q;
  assign dig       = dig_q;
  assign frame     = frame_q;

endmodule

// File: tb/tb_segdisp_scan.sv
// Directed bench for segdisp_scan: a 4-digit active-low-segment instance and an
// 8-digit inverted-polarity instance sharing clock and reset.
module tb_segdisp_scan;
  import segdisp_scan_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] seg_a, seg_b;
  logic [3:0] dig_a;
  logic [7:0] dig_b;
  logic       frame_a, frame_b;

  segdisp_scan_if bus_a ();
  segdisp_scan_if bus_b ();

  segdisp_scan #(.DIGITS(4), .DIV(4), .BLANK(1), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .seg(seg_a), .dig(dig_a), .frame(frame_a));

  segdisp_scan #(.DIGITS(8), .DIV(4), .BLANK(1), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .seg(seg_b), .dig(dig_b), .frame(frame_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Timing model: k = clk edges since reset release; outputs after edge k show
  // prescaler (k-1)%4 and slot ((k-1)/4)%DIGITS.
  int k = 0;
  int cnt_o = 0;
  int slot_o = 0;
  int slot_ob = 0;
  bit model_on = 1'b0;
  bit en_m = 1'b1;
  int frames = 0;

  typedef struct {
    logic       wr;
    logic [3:0] waddr;
    logic [7:0] wdata;
    int         slot;
    logic [7:0] exp_seg;
    logic [3:0] raddr;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", name, act, exp, k);
    end
  endtask

  task automatic tick();
    bit en_used;
    logic [3:0] exp_dig;
    en_used = en_m;
    @(posedge clk);
    #1;
    if (model_on) begin
      k++;
      cnt_o   = (k - 1) % 4;
      slot_o  = ((k - 1) / 4) % 4;
      slot_ob = ((k - 1) / 4) % 8;
      exp_dig = (en_used && cnt_o >= 1) ? 4'(1 << slot_o) : 4'h0;
      check("dig_scan", 32'(dig_a), 32'(exp_dig));
      check("frame", 32'(frame_a), 32'((k % 16) == 0));
      if (frame_a) frames++;
    end
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [7:0] d);
    bus_a.cs = 1'b1; bus_a.we = 1'b1; bus_a.addr = a; bus_a.wdata = d;
    tick();
    bus_a.cs = 1'b0; bus_a.we = 1'b0;
    if (a == 4'd3) en_m = d[0];
  endtask

  task automatic goto_slot(input int s);
    tick();
    for (int i = 0; i < 40 && !(cnt_o == 1 && slot_o == s); i++) tick();
  endtask

  task automatic goto_slot_b(input int s);
    tick();
    for (int i = 0; i < 80 && !(cnt_o == 1 && slot_ob == s); i++) tick();
  endtask

  initial begin
    bus_a.cs = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.cs = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;

    //            wr    waddr  wdata  slot exp_seg raddr  exp_rd
    vecs[0]  = '{1'b1, 4'h0, 8'h21, 0, 8'hF9, 4'h0, 8'h21};
    vecs[1]  = '{1'b1, 4'h1, 8'h43, 1, 8'hA4, 4'h1, 8'h43};
    vecs[2]  = '{1'b0, 4'h0, 8'h00, 2, 8'hB0, 4'h3, 8'h01};
    vecs[3]  = '{1'b0, 4'h0, 8'h00, 3, 8'h99, 4'h2, 8'h00};
    vecs[4]  = '{1'b1, 4'h2, 8'h04, 2, 8'h30, 4'h2, 8'h04};
    vecs[5]  = '{1'b0, 4'h0, 8'h00, 3, 8'h99, 4'h7, 8'h00};
    vecs[6]  = '{1'b1, 4'h7, 8'h5A, 1, 8'hA4, 4'h7, 8'h00};
    vecs[7]  = '{1'b1, 4'h3, 8'hFF, 0, 8'hF9, 4'h3, 8'h03};
    vecs[8]  = '{1'b1, 4'h0, 8'h05, 1, 8'hC0, 4'h0, 8'h05};
    vecs[9]  = '{1'b1, 4'h1, 8'h00, 3, 8'hFF, 4'h1, 8'h00};
    vecs[10] = '{1'b0, 4'h0, 8'h00, 2, 8'h7F, 4'h4, 8'h00};
    vecs[11] = '{1'b0, 4'h0, 8'h00, 1, 8'hFF, 4'h3, 8'h03};
    vecs[12] = '{1'b0, 4'h0, 8'h00, 0, 8'h92, 4'h0, 8'h05};
    vecs[13] = '{1'b1, 4'h0, 8'h00, 0, 8'hC0, 4'h0, 8'h00};
    vecs[14] = '{1'b1, 4'h2, 8'h00, 2, 8'hFF, 4'hF, 8'h00};

    // Reset held for three clks
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_seg_a", 32'(seg_a), 32'hFF);
      check("rst_dig_a", 32'(dig_a), 32'h0);
      check("rst_frame_a", 32'(frame_a), 32'h0);
    end
    check("rst_seg_b", 32'(seg_b), 32'h00);
    check("rst_dig_b", 32'(dig_b), 32'hFF);

    rst = 1'b1;
    model_on = 1'b1;
    tick();
    check("release_blank", 32'(dig_a), 32'h0);
    tick();
    check("release_dig", 32'(dig_a), 32'h1);

    // Polarity instance: glyph 8 on digit 0, glyph 0 on digit 1
    bus_b.cs = 1'b1; bus_b.we = 1'b1; bus_b.addr = 4'h0; bus_b.wdata = 8'h08;
    tick();
    bus_b.cs = 1'b0; bus_b.we = 1'b0;
    goto_slot_b(0);
    check("pol_seg_d0", 32'(seg_b), 32'h7F);
    check("pol_dig_d0", 32'(dig_b), 32'hFE);
    goto_slot_b(1);
    check("pol_seg_d1", 32'(seg_b), 32'h3F);
    check("pol_dig_d1", 32'(dig_b), 32'hFD);

    for (int v = 0; v < 15; v++) begin
      if (vecs[v].wr) wr_a(vecs[v].waddr, vecs[v].wdata);
      goto_slot(vecs[v].slot);
      check($sformatf("vec%0d_seg", v), 32'(seg_a), 32'(vecs[v].exp_seg));
      bus_a.addr = vecs[v].raddr;
      #1;
      check($sformatf("vec%0d_rdata", v), 32'(bus_a.rdata), 32'(vecs[v].exp_rd));
    end

    // Write during an active slot updates its glyph one clk later
    goto_slot(1);
    wr_a(4'h0, 8'h70);
    check("midslot_old_seg", 32'(seg_a), 32'hFF);
    tick();
    check("midslot_new_seg", 32'(seg_a), 32'hF8);
    check("midslot_dig", 32'(dig_a), 32'h2);

    // Disable mid-slot; scan keeps running underneath
    goto_slot(2);
    wr_a(4'h3, 8'h00);
    tick();
    check("dis_dig", 32'(dig_a), 32'h0);
    check("dis_seg", 32'(seg_a), 32'hFF);
    frames = 0;
    for (int i = 0; i < 32; i++) tick();
    check("dis_frames", 32'(frames), 32'd2);
    check("dis_seg_hold", 32'(seg_a), 32'hFF);
    wr_a(4'h3, 8'h01);
    goto_slot(3);
    check("resume_seg", 32'(seg_a), 32'hC0);
    check("resume_dig", 32'(dig_a), 32'h8);

    // Reset in the middle of a slot
    goto_slot(1);
    tick();
    rst = 1'b0;
    model_on = 1'b0;
    tick();
    check("midrst_seg_a", 32'(seg_a), 32'hFF);
    check("midrst_dig_a", 32'(dig_a), 32'h0);
    check("midrst_frame_a", 32'(frame_a), 32'h0);
    check("midrst_seg_b", 32'(seg_b), 32'h00);
    check("midrst_dig_b", 32'(dig_b), 32'hFF);
    check("midrst_frame_b", 32'(frame_b), 32'h0);
    bus_a.addr = 4'h0;
    #1;
    check("midrst_data", 32'(bus_a.rdata), 32'h00);
    bus_a.addr = 4'h3;
    #1;
    check("midrst_ctrl", 32'(bus_a.rdata), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/segdisp_scan.md
SEGDISP_SCAN -- requirements
Module: segdisp_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits; legal values 2, 4, 6, 8.
REQ-002 SHALL have parameter DIV, default 2048: clk cycles per digit slot; legal range 4..2^20.
REQ-003 SHALL have parameter BLANK, default 2: clk cycles at slot start with all digit enables off; legal range 0..DIV-2.
REQ-004 SHALL have parameter SEG_ACT_LOW, default 1: 1 means segment and DP outputs drive 0 to light.
REQ-005 SHALL have parameter DIG_ACT_LOW, default 0: 1 means digit enables drive 0 to select.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 rst  input  1  reset; synchronous, active-low.
REQ-008 cs  input  1  register select.
REQ-009 we  input  1  write strobe, qualified by cs.
REQ-010 addr  input  4  register address.
REQ-011 wdata  input  8  write data.
REQ-012 rdata  output  8  read data, combinational from addr.
REQ-013 seg  output  8  segments; bit 7 = DP, bits 6:0 = g..a.
REQ-014 dig  output  DIGITS  digit enables; dig[DIGITS-1] = most significant digit.
REQ-015 frame  output  1  one-clk pulse at each scan wrap.

Function
REQ-016 Register map SHALL be: addr 0..DIGITS/2-1 = data byte k (low nibble = digit 2k, high nibble = digit 2k+1); addr DIGITS/2 = DP mask (bit i = digit i); addr DIGITS/2+1 = CTRL (bit0 EN, bit1 LZS, bits 7:2 read 0).
REQ-017 A write SHALL occur when cs=1 and we=1 at a clk edge; writes to unmapped addresses SHALL be ignored; unmapped reads SHALL return 0x00.
REQ-018 The prescaler SHALL count 0..DIV-1 and wrap; each wrap SHALL advance the slot index 0,1,...,DIGITS-1,0.
REQ-019 frame SHALL be 1 for exactly the clk in which the slot index goes from DIGITS-1 to 0.
REQ-020 During prescaler counts 0..BLANK-1 all dig outputs SHALL be inactive; otherwise only dig[slot] SHALL be active.
REQ-021 Segment pattern SHALL be the hex glyph (0-9, A, b, C, d, E, F) of the slot's nibble; DP lit when DP mask bit [slot] = 1.
REQ-022 With LZS=1, digit i>0 SHALL have segments 6:0 dark when nibbles DIGITS-1..i are all zero; digit 0 SHALL never be suppressed; DP SHALL be unaffected.
REQ-023 With EN=0, all dig SHALL be inactive and seg all dark; the prescaler and slot index SHALL keep running.
REQ-024 seg and dig SHALL be registered: a change of slot, data, DP or CTRL SHALL be visible on the outputs exactly one clk later.
REQ-025 A write during an active slot SHALL update that slot's glyph on the next clk, with no wait for a slot boundary.

Reset
REQ-026 While rst=0 at a clk edge, the block SHALL set data=0, DP mask=0, CTRL EN=1, LZS=0, prescaler=0, slot=0 and frame=0, and SHALL drive seg all dark and dig all inactive, whatever the scan state.
REQ-027 After rst returns to 1, slot 0 SHALL be the first slot shown; its digit enable SHALL become active BLANK+1 clks after release.

Structure
REQ-028 The register address offsets, CTRL bit positions and the hex glyph table SHALL be defined as constants in the shared display package.
REQ-029 Hex-to-segment decoding SHALL be a separate combinational sub-module, seg7_hexdec (4-bit in, 7-bit active-high out), instantiated once.

Verification
REQ-030 Reset: DIGITS=4, DIV=4, BLANK=1; hold rst=0 for 3 clks -> seg=0xFF, dig=0000, frame=0; after release, dig=0001 on the 2nd clk.
REQ-031 Scan: write addr0=0x21, addr1=0x43 -> slots 0..3 show glyphs 1, 2, 3, 4 (seg 0xF9, 0xA4, 0xB0, 0x99); frame pulses once every 16 clks; each dig pulse lasts 3 clks after a 1-clk blank.
REQ-032 LZS: data=0x0005 and CTRL=0x03 -> digits 3..1 dark (seg=0xFF) but still strobed, digit 0 shows 0x92; data=0x0000 -> digit 0 shows 0xC0.
REQ-033 DP and readback: write addr2=0x04 -> slot 2 has seg[7]=0; read addr2 -> 0x04; read addr3 -> 0x03; read addr7 -> 0x00.
REQ-034 Disable mid-slot: write CTRL=0x00 during slot 2 -> dig=0000 on the next clk; frame keeps pulsing every 16 clks; write CTRL=0x01 -> scan resumes at the current slot with no restart.
REQ-035 Polarity sweep: DIGITS=8, SEG_ACT_LOW=0, DIG_ACT_LOW=1 -> glyph 8 drives seg=0x7F and active digit drives dig bit 0.
